id_ex_snapshot_tx: RTL
======================

// Module: id_ex_snapshot_tx
// PURPOSE
// - Debug-side reader of the ID/EX pipeline latch. On request, captures every ID/EX output field in one cycle.
// - Streams the capture as a fixed byte frame over a valid/ready byte interface to the debug UART path.
// - Sits beside ID_EX and taps its outputs. Never stalls or alters the pipeline.
// PARAMETERS
// - DATA_WIDTH  32  width of regA/regB/extendido. Must be a multiple of 8.
// - SIZEOP      6   opcode width. Must be <= 8.
// PORTS
// - i_clock      in   1           single clock, rising edge
// - i_reset      in   1           synchronous, active-low reset (asserted when 0)
// - i_start      in   1           request a snapshot; sampled only in IDLE
// - i_regA       in   DATA_WIDTH  ID/EX regA
// - i_regB       in   DATA_WIDTH  ID/EX regB
// - i_extendido  in   DATA_WIDTH  ID/EX sign-extended immediate
// - i_opcode     in   SIZEOP      ID/EX opcode
// - i_rs         in   5           ID/EX rs
// - i_rt         in   5           ID/EX rt
// - i_rd         in   5           ID/EX rd
// - i_ex         in   4           ID/EX EX controls
// - i_mem        in   3           ID/EX MEM controls
// - i_wb         in   2           ID/EX WB controls
// - i_sizemem    in   2           ID/EX memory access size
// - i_signedmem  in   1           ID/EX signed-load flag
// - o_data       out  8           current frame byte
// - o_valid      out  1           o_data is valid
// - i_ready      in   1           sink accepts o_data; a byte transfers when o_valid && i_ready
// - o_busy       out  1           high in every state except IDLE
// - o_done       out  1           1-cycle pulse after the last byte transfers
// BEHAVIOUR
// - Reset: FSM goes to IDLE; o_data=0, o_valid=0, o_busy=0, o_done=0; byte index=0.
// - FSM states: IDLE -> SEND -> [CSUM] -> DONE -> IDLE.
// - IDLE:
//   - When i_start=1, all inputs are latched into shadow registers on that edge; FSM moves to SEND.
//   - o_valid=1 with byte 0 on the next cycle (1-cycle latency).
// - Frame: W=DATA_WIDTH/8, N=3W+6 bytes. Words are sent MSB byte first.
//   - regA[W], regB[W], extendido[W]
//   - {zero-pad, opcode}
//   - {3'b0, rs}, {3'b0, rt}, {3'b0, rd}
//   - {ex, mem, signedmem}
//   - {wb, sizemem, 4'b0}
// - SEND:
//   - Index advances only on a transfer.
//   - While o_valid && !i_ready, o_data and o_valid hold stable.
//   - o_valid never drops mid-frame.
//   - When byte N-1 transfers, FSM moves to CSUM if enabled, else DONE.
// - DONE: o_valid=0, o_done=1 for exactly one cycle, then IDLE.
// - Capture is atomic: input changes after the capture edge do not affect the frame in flight.
// - i_start outside IDLE (SEND/CSUM/DONE) is ignored. No queuing.
// - The next frame can start at the earliest in the cycle after DONE.
// - i_start held high continuously: one frame per IDLE visit.
// - i_ready high with no valid data: no effect.
// - Reset mid-frame: frame aborts at the next edge; o_valid=0; no o_done; partial frame is not resumed.
// CONFIGURATION
// - ID_EX_SNAPSHOT_CSUM_EN defined:
//   - After byte N-1, state CSUM sends one extra byte: XOR of all N frame bytes.
//   - Same valid/ready rules apply. Frame is N+1 bytes; o_done follows the checksum transfer.
// - Undefined: no CSUM state; frame is exactly N bytes; no checksum logic.
// TESTING (DATA_WIDTH=32, SIZEOP=6, N=18)
// - Reset low 2 cycles, then high:
//   - o_valid=0, o_busy=0, o_done=0, o_data=0.
// - Start pulse, i_ready=1, with:
//   - regA=32'h11223344, regB=32'hAABBCCDD, extendido=32'hFFFF8000
//   - opcode=6'h23, rs=5, rt=9, rd=0, ex=4'hA, mem=3'b101, signedmem=1, wb=2'b11, sizemem=2'b10
//   - Expected 18 bytes: 11 22 33 44 AA BB CC DD FF FF 80 00 23 05 09 00 AB E0
//   - o_done pulses 1 cycle after the last byte.
// - Same frame with i_ready toggling 1,0,0,1 repeatedly:
//   - Bytes are identical; o_data is stable during every stall; no byte is dropped or duplicated.
// - After capture, change all inputs to 0 during SEND:
//   - Frame still matches the captured values.
// - i_start pulsed during SEND and during DONE:
//   - Ignored; exactly one frame is emitted.
// - Reset asserted after byte 7:
//   - o_valid=0 next cycle; no o_done.
//   - A new start yields a full correct frame from byte 0.
// - With ID_EX_SNAPSHOT_CSUM_EN: the scenario-2 frame appends a 19th byte equal to the XOR of the 18 bytes.

Source files
------------

// File: rtl/id_ex_snapshot_tx_if.sv
`default_nettype none
// id_ex_snapshot_tx_if: valid/ready byte stream from the ID/EX snapshot reader to the debug UART path.
interface id_ex_snapshot_tx_if;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;

  modport master (output o_data, output o_valid, input i_ready);
  modport slave  (input o_data, input o_valid, output i_ready);
endinterface
`default_nettype wire

// File: rtl/id_ex_snapshot_tx.sv
`default_nettype none
// id_ex_snapshot_tx: atomically captures the ID/EX latch outputs on request and streams them as a byte frame.
// Optional feature: define ID_EX_SNAPSHOT_CSUM_EN to append an XOR checksum byte after the frame.
module id_ex_snapshot_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZEOP     = 6
) (
  input  wire logic                  i_clock,
  input  wire logic                  i_reset,
  input  wire logic                  i_start,
  input  wire logic [DATA_WIDTH-1:0] i_regA,
  input  wire logic [DATA_WIDTH-1:0] i_regB,
  input  wire logic [DATA_WIDTH-1:0] i_extendido,
  input  wire logic [SIZEOP-1:0]     i_opcode,
  input  wire logic [4:0]            i_rs,
  input  wire logic [4:0]            i_rt,
  input  wire logic [4:0]            i_rd,
  input  wire logic [3:0]            i_ex,
  input  wire logic [2:0]            i_mem,
  input  wire logic [1:0]            i_wb,
  input  wire logic [1:0]            i_sizemem,
  input  wire logic                  i_signedmem,
  id_ex_snapshot_tx_if.master        tx,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int W       = DATA_WIDTH / 8;
  localparam int N       = 3 * W + 6;
  localparam int FRAME_W = 8 * N;
  localparam int IDX_W   = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

`ifdef ID_EX_SNAPSHOT_CSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, CSUM = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [7:0]           opcode_byte;
  logic [FRAME_W-1:0]   capture;
  logic                 xfer;
`ifdef ID_EX_SNAPSHOT_CSUM_EN
  logic [7:0]           csum_q, csum_d;
`endif

  assign opcode_byte = 8'(i_opcode);
  assign capture = {i_regA, i_regB, i_extendido, opcode_byte,
                    3'b000, i_rs, 3'b000, i_rt, 3'b000, i_rd,
                    i_ex, i_mem, i_signedmem,
                    i_wb, i_sizemem, 4'b0000};
  assign xfer = tx.o_valid && tx.i_ready;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      frame_q <= '0;
`ifdef ID_EX_SNAPSHOT_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
`ifdef ID_EX_SNAPSHOT_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // The frame is held in a shift register; the current byte is always the top byte.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    frame_d    = frame_q;
`ifdef ID_EX_SNAPSHOT_CSUM_EN
    csum_d     = csum_q;
`endif
    tx.o_data  = 8'h00;
    tx.o_valid = 1'b0;
    o_busy     = 1'b1;
    o_done     = 1'b0;
    case (state_q)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          frame_d = capture;
          idx_d   = '0;
`ifdef ID_EX_SNAPSHOT_CSUM_EN
          csum_d  = 8'h00;
`endif
          state_d = SEND;
        end
      end
      SEND: begin
        tx.o_data  = frame_q[FRAME_W-1 -: 8];
        tx.o_valid = 1'b1;
        if (xfer) begin
          frame_d = {frame_q[FRAME_W-9:0], 8'h00};
`ifdef ID_EX_SNAPSHOT_CSUM_EN
          csum_d  = csum_q ^ frame_q[FRAME_W-1 -: 8];
`endif
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
`ifdef ID_EX_SNAPSHOT_CSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef ID_EX_SNAPSHOT_CSUM_EN
      CSUM: begin
        tx.o_data  = csum_q;
        tx.o_valid = 1'b1;
        if (xfer) state_d = DONE;
      end
`endif
      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire
